// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
package uart_pkg;

    localparam int unsigned UART_DATA_W   = 8;
    localparam int unsigned UART_ERR_W    = 3;
    localparam int unsigned RX_FIFO_DEPTH = 16;

    // One received frame as stored in the receive buffer.
    typedef struct packed {
        logic [UART_ERR_W-1:0]  err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO of rx_entry_t with registered level/full/empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = RX_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  rx_entry_t               push_entry,
    input  logic                    pop,
    output rx_entry_t               head,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    rx_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push_ok;
    logic [LW-1:0]     level_nxt;

    // A same-cycle pop frees the slot a push needs when full.
    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        drop_c    = push && full && !pop_ok;
        level_nxt = level;
        if (push_ok && !pop_ok) begin
            level_nxt = level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: synchronises done_flag, captures each frame into a FIFO.
// Define UART_RX_FIFO_DROP_ERR_EN to discard frames with errors and pulse err_drop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = RX_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = UART_DATA_W,
    parameter int unsigned ERR_W       = UART_ERR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_done,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic [ERR_W-1:0]        rx_err,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [ERR_W-1:0]        m_err,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    ovf_clr
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    output logic                    err_drop
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   done_q;
    logic                   push_q;
    rx_entry_t              cap_q;
    rx_entry_t              head;
    logic                   push_c;
    logic                   drop_c;
    logic                   sync_last;
    logic                   sync_prev;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign sync_prev = sync_q[SYNC_STAGES-2];

    // Preset to 1 so a done level held across reset release is not a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            done_q <= 1'b1;
            push_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_done};
            done_q <= sync_last;
            push_q <= sync_last && !done_q;
        end
    end

    // Capture on the edge the synchronised level rises, so data lines up with push_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (sync_prev && !sync_last) begin
            cap_q.err  <= UART_ERR_W'(rx_err);
            cap_q.data <= UART_DATA_W'(rx_data);
        end
    end

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign push_c = push_q && (cap_q.err == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop <= 1'b0;
        end else begin
            err_drop <= push_q && (cap_q.err != '0);
        end
    end
`else
    assign push_c = push_q;
`endif

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_entry (cap_q),
        .pop        (m_ready),
        .head       (head),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .drop_c     (drop_c)
    );

    // Sticky overflow; a drop in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign m_valid = !empty;
    assign m_data  = DATA_W'(head.data);
    assign m_err   = ERR_W'(head.err);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed literals.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SYNC  = 2;

    logic        clk;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [2:0]  rx_err;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [2:0]  m_err;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        ovf_clr;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic        err_drop;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    uart_rx_fifo #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC),
        .DATA_W      (8),
        .ERR_W       (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .rx_err   (rx_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_err    (m_err),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_DROP_ERR_EN
        ,
        .err_drop (err_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames become entries SYNC+1 edges after the first edge seeing rx_done high.
    logic [10:0] mq [$];
    int          pdue [$];
    logic [10:0] pent [$];
    bit          rx_prev;
    bit          m_ovf;
    int          cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        bit          do_pop;
        bit          do_push;
        bit          drop;
        logic [10:0] e;
        if (!rst_n) begin
            mq.delete();
            pdue.delete();
            pent.delete();
            rx_prev = 1'b1;
            m_ovf   = 1'b0;
        end else begin
            cyc++;
            do_pop  = (mq.size() != 0) && m_ready;
            do_push = (pdue.size() != 0) && (pdue[0] == cyc);
            e       = '0;
            if (do_push) begin
                e = pent[0];
                void'(pdue.pop_front());
                void'(pent.pop_front());
`ifdef UART_RX_FIFO_DROP_ERR_EN
                if (e[10:8] != 3'b000) do_push = 1'b0;
`endif
            end
            if (rx_done && !rx_prev) begin
                pdue.push_back(cyc + SYNC + 1);
                pent.push_back({rx_err, rx_data});
            end
            rx_prev = rx_done;
            drop = do_push && (mq.size() == DEPTH) && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push && !drop) mq.push_back(e);
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            chk("level", 32'(level), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) begin
                chk("m_data", 32'(m_data), 32'(mq[0][7:0]));
                chk("m_err", 32'(m_err), 32'(mq[0][10:8]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] e);
        rx_data = d;
        rx_err  = e;
        rx_done = 1'b1;
        repeat (4) tick();
        rx_done = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = '0;
        rx_err  = '0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Single frame latency: m_valid rises SYNC+2 edges after rx_done rises.
        rx_data = 8'hA5;
        rx_err  = 3'b000;
        rx_done = 1'b1;
        tick();
        repeat (SYNC) tick();
        chk("single_valid_early", 32'(m_valid), 32'd0);
        tick();
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'hA5);
        chk("single_err", 32'(m_err), 32'd0);
        chk("single_level", 32'(level), 32'd1);
        tick();
        rx_done = 1'b0;
        repeat (3) tick();
        chk("single_once", 32'(level), 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("single_popped", 32'(empty), 32'd1);

        // Burst fill then drain in order; pointers wrap for the 17th frame.
        for (int i = 0; i < 16; i++) send(8'(i), 3'b000);
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_level", 32'(level), 32'd16);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("burst_order", 32'(m_data), 32'(i));
            tick();
        end
        m_ready = 1'b0;
        chk("burst_drained", 32'(empty), 32'd1);
        send(8'h10, 3'b000);
        chk("wrap_data", 32'(m_data), 32'h10);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Overflow: push into full FIFO is dropped and sets the sticky flag.
        for (int i = 0; i < 16; i++) send(8'(i), 3'b000);
        send(8'hFF, 3'b000);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_head", 32'(m_data), 32'h00);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full with a pop on the push edge: push accepted, no overflow.
        rx_data = 8'hEE;
        rx_err  = 3'b000;
        rx_done = 1'b1;
        tick();
        repeat (SYNC) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        rx_done = 1'b0;
        repeat (3) tick();
        chk("fullpop_level", 32'(level), 32'd16);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_head", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fullpop_order", 32'(m_data), (i < 15) ? 32'(i + 1) : 32'hEE);
            tick();
        end
        m_ready = 1'b0;
        chk("fullpop_drained", 32'(empty), 32'd1);

        // Error flags travel with the data.
        send(8'h3C, 3'b101);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("err_dropped", 32'(level), 32'd0);
`else
        chk("err_data", 32'(m_data), 32'h3C);
        chk("err_flags", 32'(m_err), 32'b101);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
`endif

        // Reset mid-operation with a frame in flight and rx_done held across release.
        send(8'h51, 3'b000);
        send(8'h52, 3'b001);
        send(8'h53, 3'b000);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("pre_rst_level", 32'(level), 32'd2);
`else
        chk("pre_rst_level", 32'(level), 32'd3);
`endif
        rx_data = 8'h60;
        rx_done = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_now_level", 32'(level), 32'd0);
        chk("rst_now_empty", 32'(empty), 32'd1);
        chk("rst_now_valid", 32'(m_valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("held_no_push", 32'(empty), 32'd1);
        rx_done = 1'b0;
        repeat (2) tick();
        send(8'h77, 3'b000);
        chk("post_rst_data", 32'(m_data), 32'h77);
        chk("post_rst_level", 32'(level), 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("post_rst_empty", 32'(empty), 32'd1);

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Detects each completed frame from the receiver's done_flag.
- Captures the 8-bit data_out and 3-bit error_flag as one 11-bit entry in a synchronous FIFO.
- Presents entries to the host/bus side through a valid/ready handshake, with fill level and sticky overflow status.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, minimum 2
- SYNC_STAGES, 2, synchroniser flops on rx_done; minimum 2
- DATA_W, 8, received data width
- ERR_W, 3, error flag width

Ports:
- clk  input  1  system clock, same clock that feeds the receiver's baud generator
- rst_n  input  1  asynchronous active-low reset
- rx_done  input  1  receiver done_flag; level, held high for one or more clk cycles per frame
- rx_data  input  DATA_W  receiver data_out; stable while rx_done is high
- rx_err  input  ERR_W  receiver error_flag; stable while rx_done is high
- m_valid  output  1  head entry available
- m_ready  input  1  consumer accepts head entry
- m_data  output  DATA_W  head entry data
- m_err  output  ERR_W  head entry error flags, stored verbatim
- level  output  $clog2(DEPTH)+1  current number of entries
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- overflow  output  1  sticky: at least one frame dropped
- ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr, rd_ptr, level, overflow cleared; m_valid 0, empty 1, full 0.
  - All synchroniser flops and the edge-detect flop preset to 1. An rx_done held high across reset release is not captured; capture requires a low-to-high transition.
  - Memory contents are not reset. m_data/m_err are don't-care while empty.
- Capture:
  - rx_done passes through SYNC_STAGES flops; rising edge of the synchronised level produces a 1-cycle push strobe.
  - rx_data/rx_err are registered into a capture register on the same edge as the last sync stage, so the captured values align with the strobe.
  - One push per rx_done high period, regardless of how long rx_done stays high.
  - Latency from rx_done rising (first sampling edge) to push strobe: SYNC_STAGES+1 cycles. m_valid rises the cycle after the push.
- Read:
  - m_valid = !empty.
  - m_data/m_err are show-ahead, driven from mem[rd_ptr].
  - Pop occurs when m_valid && m_ready; rd_ptr advances at that edge.
  - m_ready while empty has no effect.
- Level arithmetic:
  - push only: level+1; pop only: level-1; push and pop together: level unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Full boundary:
  - push while full without a pop: frame dropped, pointers and level unchanged, overflow set next cycle.
  - push while full with a same-cycle pop: push accepted, no overflow.
- Overflow:
  - Sticky until ovf_clr is high at a clock edge.
  - If a drop and ovf_clr occur in the same cycle, overflow stays 1 (set wins).
- Reset mid-operation: all pending entries are discarded immediately. An in-flight sync pulse is lost.
- No combinational path from rx_* to any output.

Optional Feature:
- Macro UART_RX_FIFO_DROP_ERR_EN.
- Defined:
  - A captured frame with rx_err != 0 is not written to the FIFO.
  - An additional output err_drop (1 bit) pulses high for one cycle on each discarded frame.
  - Discarded frames never set overflow.
- Undefined: every frame is stored with its error bits; no err_drop port exists.

Decomposition:
- Shared package uart_pkg holds:
  - constants UART_DATA_W=8 and UART_ERR_W=3
  - typedef rx_entry_t as a packed struct {err[2:0], data[7:0]}
  - localparam default RX_FIFO_DEPTH=16
- One sub-module: uart_sync_fifo.
  - Parameterised synchronous FIFO storing rx_entry_t.
  - Provides level/full/empty and push/pop.
- Synchroniser and edge detect stay in the top module.

Test Plan:
- Single frame: rx_done high 5 cycles, rx_data=8'hA5, rx_err=3'b000 -> exactly one push. m_valid rises SYNC_STAGES+2 cycles after rx_done; m_data=A5, m_err=0, level=1. Pop with m_ready -> empty=1.
- Burst/ordering: 16 frames 8'h00..8'h0F, m_ready=0 -> full=1, level=16. Drain -> values come out in order; pointers wrap and a 17th frame 8'h10 reads correctly.
- Overflow: fill to 16, send frame 8'hFF -> dropped, overflow=1, level=16, head still 8'h00. Pulse ovf_clr -> overflow=0.
- Full with simultaneous pop: level=16, m_ready=1 in the same cycle as the push strobe -> level stays 16, overflow=0, last entry is the new frame.
- Error passthrough: frame 8'h3C with rx_err=3'b101 -> m_err=3'b101. With UART_RX_FIFO_DROP_ERR_EN defined -> no entry written, err_drop pulses once.
- Reset: rst_n low with 3 entries queued and rx_done high -> level=0, empty=1 immediately. After release with rx_done still high -> no push until rx_done goes low then high again.
